// File: rtl/priv_satp_ctrl.sv
// Privilege level, misa.C and satp ownership for program_state packing.
// satp writes are committed only after a TLB-flush handshake (or timeout).
module priv_satp_ctrl #(
  parameter logic [1:0] RESET_PRIV    = 2'b11,
  parameter int         FLUSH_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_trap_valid,
  input  logic        i_trap_to_s,
  input  logic        i_mret,
  input  logic        i_sret,
  input  logic        i_isa_c_wr_valid,
  input  logic        i_isa_c_wr_data,
  input  logic        i_satp_wr_valid,
  input  logic [31:0] i_satp_wr_data,
  output logic        o_satp_wr_ready,
  output logic        o_tlb_flush_req,
  input  logic        i_tlb_flush_ack,
  output logic [1:0]  o_priv,
  output logic        o_isa_c,
  output logic [31:0] o_satp,
  output logic        o_illegal_xret,
  output logic        o_flush_timeout,
  output logic        o_ps_changed,
  input  logic [31:0] i_log_fd
);

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam int CW = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t          state;
  logic [1:0]      mpp;
  logic            spp;
  logic [31:0]     pending;
  logic [CW-1:0]   cnt;

  logic [1:0]      priv_n;
  logic [1:0]      mpp_n;
  logic            spp_n;
  logic            illegal_n;
  logic            isa_c_n;
  logic            timeout_hit;
  logic            commit;

  // The log descriptor only feeds simulation-side tracing elsewhere.
  logic unused_log_fd;
  assign unused_log_fd = ^i_log_fd;

  always_comb begin
    priv_n    = o_priv;
    mpp_n     = mpp;
    spp_n     = spp;
    illegal_n = 1'b0;
    if (i_trap_valid) begin
      if (i_trap_to_s && (o_priv != PRIV_M)) begin
        spp_n  = o_priv[0];
        priv_n = PRIV_S;
      end else begin
        mpp_n  = o_priv;
        priv_n = PRIV_M;
      end
    end else if (i_mret) begin
      if (o_priv == PRIV_M) begin
        priv_n = mpp;
        mpp_n  = PRIV_U;
      end else begin
        illegal_n = 1'b1;
      end
    end else if (i_sret) begin
      if (o_priv != PRIV_U) begin
        priv_n = {1'b0, spp};
        spp_n  = 1'b0;
      end else begin
        illegal_n = 1'b1;
      end
    end
  end

  always_comb begin
    isa_c_n     = i_isa_c_wr_valid ? i_isa_c_wr_data : o_isa_c;
    timeout_hit = (FLUSH_TIMEOUT != 0) && (cnt == CNT_LAST) && !i_tlb_flush_ack;
    commit      = (state == S_FLUSH) && (i_tlb_flush_ack || timeout_hit);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_priv          <= RESET_PRIV;
      mpp             <= PRIV_U;
      spp             <= 1'b0;
      o_isa_c         <= 1'b1;
      o_satp          <= '0;
      pending         <= '0;
      cnt             <= '0;
      state           <= S_IDLE;
      o_satp_wr_ready <= 1'b1;
      o_tlb_flush_req <= 1'b0;
      o_illegal_xret  <= 1'b0;
      o_flush_timeout <= 1'b0;
      o_ps_changed    <= 1'b0;
    end else begin
      o_priv          <= priv_n;
      mpp             <= mpp_n;
      spp             <= spp_n;
      o_isa_c         <= isa_c_n;
      o_illegal_xret  <= illegal_n;
      o_flush_timeout <= 1'b0;
      o_ps_changed    <= (priv_n != o_priv) || (isa_c_n != o_isa_c) ||
                         (commit && (pending != o_satp));
      case (state)
        S_IDLE: begin
          if (i_satp_wr_valid) begin
            pending         <= i_satp_wr_data;
            cnt             <= '0;
            state           <= S_FLUSH;
            o_satp_wr_ready <= 1'b0;
            o_tlb_flush_req <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (commit) begin
            o_satp          <= pending;
            state           <= S_IDLE;
            o_satp_wr_ready <= 1'b1;
            o_tlb_flush_req <= 1'b0;
            o_flush_timeout <= timeout_hit;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priv_satp_ctrl.sv
// Directed bench for priv_satp_ctrl: privilege vector table plus satp flush sequences.
module tb_priv_satp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap, to_s, mret, sret, cwv, cwd;
  logic        sv_a, ack_a, sv_t, ack_t;
  logic [31:0] sd_a, sd_t;
  logic        rdy_a, req_a, ill_a, to_a, ps_a, isa_a;
  logic        rdy_t, req_t, ill_t, to_t, ps_t, isa_t;
  logic [1:0]  priv_a, priv_t;
  logic [31:0] satp_a, satp_t;
  logic [31:0] log_fd = 32'h1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  priv_satp_ctrl dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_trap_valid(trap), .i_trap_to_s(to_s),
    .i_mret(mret), .i_sret(sret), .i_isa_c_wr_valid(cwv), .i_isa_c_wr_data(cwd),
    .i_satp_wr_valid(sv_a), .i_satp_wr_data(sd_a), .o_satp_wr_ready(rdy_a),
    .o_tlb_flush_req(req_a), .i_tlb_flush_ack(ack_a), .o_priv(priv_a),
    .o_isa_c(isa_a), .o_satp(satp_a), .o_illegal_xret(ill_a),
    .o_flush_timeout(to_a), .o_ps_changed(ps_a), .i_log_fd(log_fd)
  );

  priv_satp_ctrl #(.FLUSH_TIMEOUT(4)) dut_t (
    .i_clk(clk), .i_rst_n(rst_n), .i_trap_valid(trap), .i_trap_to_s(to_s),
    .i_mret(mret), .i_sret(sret), .i_isa_c_wr_valid(cwv), .i_isa_c_wr_data(cwd),
    .i_satp_wr_valid(sv_t), .i_satp_wr_data(sd_t), .o_satp_wr_ready(rdy_t),
    .o_tlb_flush_req(req_t), .i_tlb_flush_ack(ack_t), .o_priv(priv_t),
    .o_isa_c(isa_t), .o_satp(satp_t), .o_illegal_xret(ill_t),
    .o_flush_timeout(to_t), .o_ps_changed(ps_t), .i_log_fd(log_fd)
  );

  typedef struct {
    logic       trap, to_s, mret, sret, cwv, cwd;
    logic [1:0] e_priv;
    logic       e_isa, e_ill, e_ps;
  } vec_t;

  vec_t v[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {trap, to_s, mret, sret, cwv, cwd} = '0;
    {sv_a, ack_a, sv_t, ack_t} = '0;
    sd_a = '0;
    sd_t = '0;

    //        trap to_s mret sret cwv cwd  priv   isa ill ps
    v[0]  = '{0, 0, 0, 0, 0, 0, 2'd3, 1, 0, 0};
    v[1]  = '{1, 1, 0, 0, 0, 0, 2'd3, 1, 0, 0};  // M stays M, MPP=3
    v[2]  = '{0, 0, 1, 0, 0, 0, 2'd3, 1, 0, 0};  // mret to MPP=3, MPP=U
    v[3]  = '{0, 0, 1, 0, 0, 0, 2'd0, 1, 0, 1};
    v[4]  = '{0, 0, 0, 1, 0, 0, 2'd0, 1, 1, 0};  // sret in U illegal
    v[5]  = '{0, 0, 1, 0, 0, 0, 2'd0, 1, 1, 0};  // mret in U illegal
    v[6]  = '{1, 1, 0, 0, 0, 0, 2'd1, 1, 0, 1};  // SPP=0
    v[7]  = '{1, 1, 0, 0, 0, 0, 2'd1, 1, 0, 0};  // SPP=1
    v[8]  = '{0, 0, 1, 0, 0, 0, 2'd1, 1, 1, 0};  // mret in S illegal
    v[9]  = '{0, 0, 0, 1, 0, 0, 2'd1, 1, 0, 0};  // back to S, SPP=0
    v[10] = '{0, 0, 0, 1, 0, 0, 2'd0, 1, 0, 1};
    v[11] = '{1, 0, 0, 0, 0, 0, 2'd3, 1, 0, 1};  // MPP=0
    v[12] = '{0, 0, 0, 0, 1, 0, 2'd3, 0, 0, 1};
    v[13] = '{0, 0, 0, 0, 1, 0, 2'd3, 0, 0, 0};  // same value, no pulse
    v[14] = '{1, 0, 1, 1, 1, 1, 2'd3, 1, 0, 1};  // trap wins, MPP=3
    v[15] = '{0, 0, 1, 0, 0, 0, 2'd3, 1, 0, 0};
    v[16] = '{0, 0, 1, 0, 0, 0, 2'd0, 1, 0, 1};

    #12;
    chk("rst_priv", 32'(priv_a), 32'd3);
    chk("rst_isa", 32'(isa_a), 32'd1);
    chk("rst_satp", satp_a, 32'h0);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_req", 32'(req_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      trap = v[i].trap; to_s = v[i].to_s; mret = v[i].mret;
      sret = v[i].sret; cwv = v[i].cwv; cwd = v[i].cwd;
      tick();
      chk($sformatf("v%0d_priv", i), 32'(priv_a), 32'(v[i].e_priv));
      chk($sformatf("v%0d_isa", i), 32'(isa_a), 32'(v[i].e_isa));
      chk($sformatf("v%0d_ill", i), 32'(ill_a), 32'(v[i].e_ill));
      chk($sformatf("v%0d_ps", i), 32'(ps_a), 32'(v[i].e_ps));
    end
    @(negedge clk);
    {trap, to_s, mret, sret, cwv, cwd} = '0;

    // satp write with ack after 5 cycles in FLUSH
    sv_a = 1'b1; sd_a = 32'h8000_1234;
    tick();
    chk("wr_req", 32'(req_a), 32'd1);
    chk("wr_ready", 32'(rdy_a), 32'd0);
    chk("wr_satp_old", satp_a, 32'h0);
    @(negedge clk);
    sv_a = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("wr_still_req", 32'(req_a), 32'd1);
    @(negedge clk);
    ack_a = 1'b1;
    tick();
    chk("ack_satp", satp_a, 32'h8000_1234);
    chk("ack_ps", 32'(ps_a), 32'd1);
    chk("ack_ready", 32'(rdy_a), 32'd1);
    chk("ack_req", 32'(req_a), 32'd0);
    chk("ack_no_to", 32'(to_a), 32'd0);
    @(negedge clk);
    tick();
    chk("ack_ps_once", 32'(ps_a), 32'd0);
    chk("idle_ack_ignored", 32'(req_a), 32'd0);

    // identical value rewrite: commits but no ps pulse
    @(negedge clk);
    ack_a = 1'b0; sv_a = 1'b1;
    tick();
    @(negedge clk);
    sv_a = 1'b0; ack_a = 1'b1;
    tick();
    chk("same_satp", satp_a, 32'h8000_1234);
    chk("same_ps", 32'(ps_a), 32'd0);

    // privilege events during FLUSH leave the flush alone
    @(negedge clk);
    ack_a = 1'b0; sv_a = 1'b1; sd_a = 32'h0000_0001;
    tick();
    @(negedge clk);
    sv_a = 1'b0; trap = 1'b1; mret = 1'b1; cwv = 1'b1; cwd = 1'b0;
    tick();
    chk("mix_priv", 32'(priv_a), 32'd3);
    chk("mix_isa", 32'(isa_a), 32'd0);
    chk("mix_req", 32'(req_a), 32'd1);
    chk("mix_satp", satp_a, 32'h8000_1234);
    @(negedge clk);
    {trap, mret, cwv} = '0;
    ack_a = 1'b1;
    tick();
    chk("mix_commit", satp_a, 32'h0000_0001);
    @(negedge clk);
    ack_a = 1'b0;

    // timeout instance: commit after 4 FLUSH cycles, no ack
    sv_t = 1'b1; sd_t = 32'h0000_ABCD;
    tick();
    chk("to_req", 32'(req_t), 32'd1);
    @(negedge clk);
    sd_t = 32'h5555_5555;
    tick();
    chk("to_busy_ready", 32'(rdy_t), 32'd0);
    tick();
    tick();
    chk("to_pre_satp", satp_t, 32'h0);
    chk("to_pre_pulse", 32'(to_t), 32'd0);
    @(negedge clk);
    sv_t = 1'b0;
    tick();
    chk("to_satp", satp_t, 32'h0000_ABCD);
    chk("to_pulse", 32'(to_t), 32'd1);
    chk("to_req_drop", 32'(req_t), 32'd0);
    tick();
    chk("to_pulse_once", 32'(to_t), 32'd0);

    // async reset mid-FLUSH
    @(negedge clk);
    sv_t = 1'b1; sd_t = 32'h0000_0077;
    tick();
    @(negedge clk);
    sv_t = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(req_t), 32'd0);
    chk("arst_satp", satp_t, 32'h0);
    chk("arst_ready", 32'(rdy_t), 32'd1);
    chk("arst_isa", 32'(isa_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_stays_idle", 32'(req_t), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
